// File: rtl/spi_byte_master.sv
// ============================================================================
//  Module   : spi_byte_master
//  Purpose  : Single-byte SPI master, mode 0 (CPOL=0, CPHA=0). Shifts one
//             8-bit word out on dout/sck under an active-low ss, captures
//             8 bits from din, and pulses done for one clk per byte so a
//             feeder can stream bytes back-to-back.
//  Ports    : clk   - system clock, rising-edge
//             rstb  - asynchronous active-low reset
//             mlb   - bit order, 1 = MSB first, 0 = LSB first (tx and rx)
//             start - level request, sampled only while idle
//             tdat  - byte to transmit, captured at launch
//             cdiv  - sck period select: 4/8/16/32 clk for 00/01/10/11
//             din   - serial data from slave, sampled on rising sck
//             ss    - slave select, active-low
//             sck   - serial clock, idles low
//             dout  - serial data to slave, changes on falling sck
//             done  - one-cycle end-of-byte pulse
//             rdata - last received byte, updated with done
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_byte_master (
  input  logic       clk,
  input  logic       rstb,
  input  logic       mlb,
  input  logic       start,
  input  logic [7:0] tdat,
  input  logic [1:0] cdiv,
  input  logic       din,
  output logic       ss,
  output logic       sck,
  output logic       dout,
  output logic       done,
  output logic [7:0] rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] tx_sh, tx_sh_nxt;
  logic [7:0] rx_sh, rx_sh_nxt;
  logic [7:0] rdata_nxt;
  logic [3:0] hcnt, hcnt_nxt;
  logic [3:0] bcnt, bcnt_nxt;
  logic       ss_nxt, sck_nxt, dout_nxt, done_nxt;
  logic [3:0] hlast;
  logic       half_end;

  // Terminal count of the half-period counter (H-1).
  always_comb begin
    case (cdiv)
      2'b00:   hlast = 4'd1;
      2'b01:   hlast = 4'd3;
      2'b10:   hlast = 4'd7;
      default: hlast = 4'd15;
    endcase
  end

  assign half_end = (hcnt == hlast);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      tx_sh <= 8'h00;
      rx_sh <= 8'h00;
      rdata <= 8'h00;
      hcnt  <= 4'd0;
      bcnt  <= 4'd0;
      ss    <= 1'b1;
      sck   <= 1'b0;
      dout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      tx_sh <= tx_sh_nxt;
      rx_sh <= rx_sh_nxt;
      rdata <= rdata_nxt;
      hcnt  <= hcnt_nxt;
      bcnt  <= bcnt_nxt;
      ss    <= ss_nxt;
      sck   <= sck_nxt;
      dout  <= dout_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tx_sh_nxt = tx_sh;
    rx_sh_nxt = rx_sh;
    rdata_nxt = rdata;
    hcnt_nxt  = hcnt;
    bcnt_nxt  = bcnt;
    ss_nxt    = ss;
    sck_nxt   = sck;
    dout_nxt  = dout;
    done_nxt  = done;

    case (state)
      IDLE: begin
        ss_nxt   = 1'b1;
        sck_nxt  = 1'b0;
        done_nxt = 1'b0;
        if (start) begin
          tx_sh_nxt = tdat;
          dout_nxt  = mlb ? tdat[7] : tdat[0];
          ss_nxt    = 1'b0;
          hcnt_nxt  = 4'd0;
          bcnt_nxt  = 4'd0;
          state_nxt = SEND;
        end
      end

      SEND: begin
        if (half_end) begin
          hcnt_nxt = 4'd0;
          sck_nxt  = ~sck;
          if (!sck) begin
            // Rising edge: sample din.
            rx_sh_nxt = mlb ? {rx_sh[6:0], din} : {din, rx_sh[7:1]};
            bcnt_nxt  = bcnt + 4'd1;
          end else if (bcnt < 4'd8) begin
            // Falling edge mid-byte: present the next tx bit.
            tx_sh_nxt = mlb ? {tx_sh[6:0], 1'b0} : {1'b0, tx_sh[7:1]};
            dout_nxt  = mlb ? tx_sh[6] : tx_sh[1];
          end else begin
            // Falling edge after the 8th rise ends the byte; dout holds.
            state_nxt = FINISH;
          end
        end else begin
          hcnt_nxt = hcnt + 4'd1;
        end
      end

      FINISH: begin
        ss_nxt    = 1'b1;
        done_nxt  = 1'b1;
        rdata_nxt = rx_sh;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_byte_master.sv
// ============================================================================
//  Module   : tb_spi_byte_master
//  Purpose  : Directed self-checking bench for spi_byte_master: reset,
//             MSB/LSB transfers at two divider settings, streaming,
//             mid-byte abort and a stopped clock mid-byte.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_byte_master;

  logic       clk    = 1'b0;
  logic       clk_en = 1'b1;
  logic       rstb   = 1'b0;
  logic       mlb    = 1'b1;
  logic       start  = 1'b0;
  logic [7:0] tdat   = 8'h00;
  logic [1:0] cdiv   = 2'b00;
  logic       loop   = 1'b0;
  logic       din_val = 1'b0;
  logic       din;
  logic       ss, sck, dout, done;
  logic [7:0] rdata;

  int tests = 0;
  int fails = 0;

  assign din = loop ? dout : din_val;

  spi_byte_master dut (
    .clk   (clk),
    .rstb  (rstb),
    .mlb   (mlb),
    .start (start),
    .tdat  (tdat),
    .cdiv  (cdiv),
    .din   (din),
    .ss    (ss),
    .sck   (sck),
    .dout  (dout),
    .done  (done),
    .rdata (rdata)
  );

  // 10 ns clock that can be stopped (held at its current level).
  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one byte, then watch `budget` cycles. `seen` collects dout at
  // each rising sck, first bit in the MSB. Cycle numbers are relative to
  // the launch edge t0. If gate_at > 0 the clock is stopped for 100 ns
  // before that cycle and the outputs must not move.
  task automatic xfer(input logic [7:0] b, input logic m, input logic [1:0] cd,
                      input int budget, input int gate_at,
                      output logic [7:0] seen, output int done_at,
                      output int rise1, output int hi_len, output int lo_len,
                      output int n_done);
    int rises, falls, rt0, ft0, rt1;
    logic prev;
    logic [3:0] snap;
    tdat  = b;
    mlb   = m;
    cdiv  = cd;
    start = 1'b1;
    step();
    check("launch_ss", {31'd0, ss}, 32'd0);
    check("launch_dout", {31'd0, dout}, {31'd0, (m ? b[7] : b[0])});
    start   = 1'b0;
    seen    = 8'h00;
    done_at = -1;
    n_done  = 0;
    rises   = 0;
    falls   = 0;
    rt0     = -1;
    ft0     = -1;
    rt1     = -1;
    prev    = sck;
    for (int k = 1; k <= budget; k++) begin
      if (k == gate_at) begin
        snap   = {ss, sck, dout, done};
        clk_en = 1'b0;
        #100;
        check("gate_frozen", {28'd0, ss, sck, dout, done}, {28'd0, snap});
        clk_en = 1'b1;
      end
      step();
      if (sck && !prev) begin
        seen = {seen[6:0], dout};
        if (rises == 0) rt0 = k;
        else if (rises == 1) rt1 = k;
        rises++;
      end
      if (!sck && prev) begin
        if (falls == 0) ft0 = k;
        falls++;
      end
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = k;
        check("done_ss_high", {31'd0, ss}, 32'd1);
      end
      prev = sck;
    end
    rise1  = rt0;
    hi_len = ft0 - rt0;
    lo_len = rt1 - ft0;
  endtask

  logic [7:0] seen, sh;
  logic [7:0] bytes [3];
  int         dt [3];
  int         done_at, rise1, hi_len, lo_len, n_done, nd, ss_hi, rises, cnt;
  logic       prev;

  initial begin
    // ---------------- reset with start held high ----------------
    rstb  = 1'b0;
    start = 1'b1;
    tdat  = 8'hFF;
    repeat (3) step();
    check("rst_ss",    {31'd0, ss},   32'd1);
    check("rst_sck",   {31'd0, sck},  32'd0);
    check("rst_dout",  {31'd0, dout}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'h00);
    start = 1'b0;
    rstb  = 1'b1;
    step();
    check("idle_ss", {31'd0, ss}, 32'd1);

    // ---------------- MSB first, cdiv=00, A5 loopback ----------------
    loop = 1'b1;
    xfer(8'hA5, 1'b1, 2'b00, 35, 0, seen, done_at, rise1, hi_len, lo_len, n_done);
    check("a5_bits",    {24'd0, seen}, 32'hA5);
    check("a5_rise1",   rise1,   2);
    check("a5_hi",      hi_len,  2);
    check("a5_lo",      lo_len,  2);
    check("a5_done_at", done_at, 33);
    check("a5_ndone",   n_done,  1);
    check("a5_rdata",   {24'd0, rdata}, 32'hA5);

    // ---------------- LSB first, cdiv=11, 01 with din=1 ----------------
    loop    = 1'b0;
    din_val = 1'b1;
    xfer(8'h01, 1'b0, 2'b11, 259, 0, seen, done_at, rise1, hi_len, lo_len, n_done);
    check("lsb_bits",    {24'd0, seen}, 32'h80);
    check("lsb_rise1",   rise1,   16);
    check("lsb_hi",      hi_len,  16);
    check("lsb_lo",      lo_len,  16);
    check("lsb_done_at", done_at, 257);
    check("lsb_ndone",   n_done,  1);
    check("lsb_rdata",   {24'd0, rdata}, 32'hFF);

    // ---------------- streaming 10,20,30 ----------------
    loop  = 1'b1;
    mlb   = 1'b1;
    cdiv  = 2'b00;
    tdat  = 8'h10;
    start = 1'b1;
    step();
    nd    = 0;
    ss_hi = 0;
    sh    = 8'h00;
    prev  = sck;
    for (int k = 1; k <= 120 && nd < 3; k++) begin
      step();
      if (sck && !prev) sh = {sh[6:0], dout};
      prev = sck;
      if (ss) ss_hi++;
      if (done) begin
        bytes[nd] = sh;
        dt[nd]    = k;
        nd++;
        if (nd == 1) tdat = 8'h20;
        else if (nd == 2) tdat = 8'h30;
        else start = 1'b0;
      end
    end
    check("stream_ndone", nd, 3);
    check("stream_b0", {24'd0, bytes[0]}, 32'h10);
    check("stream_b1", {24'd0, bytes[1]}, 32'h20);
    check("stream_b2", {24'd0, bytes[2]}, 32'h30);
    check("stream_t0", dt[0], 33);
    check("stream_gap1", dt[1] - dt[0], 34);
    check("stream_gap2", dt[2] - dt[1], 34);
    check("stream_ss_hi", ss_hi, 3);
    check("stream_rdata", {24'd0, rdata}, 32'h30);
    step();
    step();

    // ---------------- abort after 3rd rising sck ----------------
    tdat  = 8'hC3;
    mlb   = 1'b1;
    cdiv  = 2'b00;
    start = 1'b1;
    step();
    start = 1'b0;
    rises = 0;
    prev  = sck;
    for (int k = 1; k <= 20 && rises < 3; k++) begin
      step();
      if (sck && !prev) rises++;
      prev = sck;
    end
    check("abort_rises", rises, 3);
    rstb = 1'b0;
    #1;
    check("abort_ss",    {31'd0, ss},   32'd1);
    check("abort_sck",   {31'd0, sck},  32'd0);
    check("abort_dout",  {31'd0, dout}, 32'd0);
    check("abort_done",  {31'd0, done}, 32'd0);
    check("abort_rdata", {24'd0, rdata}, 32'h00);
    step();
    step();
    rstb = 1'b1;
    cnt  = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done || sck || !ss) cnt++;
    end
    check("abort_quiet", cnt, 0);
    xfer(8'h5A, 1'b1, 2'b00, 35, 0, seen, done_at, rise1, hi_len, lo_len, n_done);
    check("post_abort_bits",  {24'd0, seen}, 32'h5A);
    check("post_abort_done",  done_at, 33);
    check("post_abort_rdata", {24'd0, rdata}, 32'h5A);

    // ---------------- clock stopped mid-byte ----------------
    xfer(8'h1D, 1'b0, 2'b01, 67, 20, seen, done_at, rise1, hi_len, lo_len, n_done);
    check("gate_bits",    {24'd0, seen}, 32'hB8);
    check("gate_hi",      hi_len,  4);
    check("gate_done_at", done_at, 65);
    check("gate_ndone",   n_done,  1);
    check("gate_rdata",   {24'd0, rdata}, 32'h1D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_byte_master.md
# spi_byte_master

Single-byte SPI master that serialises an 8-bit word onto `dout`/`sck` under a low-active `ss` and captures the same number of bits from `din`. It drives the SPI command interface into the display controller and runs in the root clock domain. It raises a one-cycle `done` after each byte, so a feeder can stream bytes back-to-back.

## Interface
- No parameters. Word length is fixed at 8 bits.
- `clk` in 1: system clock. All state changes on rising edge.
- `rstb` in 1: reset, asynchronous, active-low.
- `mlb` in 1: bit order. 1 = MSB first, 0 = LSB first. Applies to both tx and rx.
- `start` in 1: level request. Sampled only in IDLE.
- `tdat` in 8: byte to transmit. Captured on the cycle the transfer launches.
- `cdiv` in 2: clock divider select. `sck` period = 4, 8, 16 or 32 clk for 00/01/10/11.
- `din` in 1: serial data from the slave.
- `ss` out 1: slave select, active-low.
- `sck` out 1: serial clock, idle low.
- `dout` out 1: serial data to the slave.
- `done` out 1: one-cycle pulse at end of byte.
- `rdata` out 8: last received byte. Stable until the next `done`.

## Operation
- SPI mode 0 (CPOL=0, CPHA=0):
  - `dout` is valid before the first rising `sck` and changes only on falling `sck`.
  - `din` is sampled on rising `sck`.
- State machine IDLE -> SEND -> FINISH -> IDLE.
- IDLE:
  - `ss`=1, `sck`=0, `done`=0.
  - If `start`=1: tx shift register <= `tdat`, `dout` <= first bit (`tdat[7]` if `mlb`, else `tdat[0]`), `ss` <= 0, half-period counter <= 0, bit counter <= 0, go to SEND.
- SEND:
  - Half-period counter H = 2, 4, 8 or 16 clk per `cdiv`. When the counter reaches H-1, toggle `sck` and clear the counter.
  - On a 0->1 toggle: shift `din` into the rx register (into the LSB and shifting left if `mlb`=1, otherwise into the MSB and shifting right), then increment the bit counter.
  - On a 1->0 toggle with bit counter < 8: shift the tx register and present the next bit on `dout`.
  - On the 1->0 toggle with bit counter = 8: go to FINISH. `dout` keeps its last bit.
- FINISH, one cycle:
  - `ss` <= 1, `done` <= 1, `rdata` <= rx register, go to IDLE.
  - `done` drops in the next cycle.
- `start` held high streams bytes continuously. Each new byte takes the `tdat` value present one clk after `done`, so a feeder may update `tdat` on the `done` edge.
- `start` deasserted mid-transfer has no effect. The byte always completes.
- `cdiv`, `mlb` changes mid-transfer: undefined. Callers must hold them stable during SEND.
- If `clk` stops (gated), all state holds and resumes cleanly.

## Timing
- Reset values: `ss`=1, `sck`=0, `dout`=0, `done`=0, `rdata`=8'h00, state IDLE, counters 0.
- `rstb` low mid-transfer aborts immediately to the reset values. There is no `done` for the aborted byte.
- Launch: `start` sampled high at edge t0 -> `ss`=0 and first `dout` bit visible after t0.
- First rising `sck` occurs H clk after t0. Each full `sck` period is 2H clk, and there are 8 periods.
- FINISH is entered at the edge of the last falling `sck` (t0 + 16H).
- `done`=1 and `ss`=1 from edge t0+16H+1 for exactly one cycle.
- Back-to-back with `start` held high: next launch at t0+16H+2.
  - Byte-to-byte period is 16H+2 clk (34 clk for `cdiv`=00).
  - `ss` is high for exactly one cycle between bytes.

## Test plan
- Reset: `rstb`=0 with `start`=1 -> `ss`=1, `sck`=0, `dout`=0, `done`=0, `rdata`=00. No activity until `rstb`=1.
- MSB first, `cdiv`=00, `tdat`=8'hA5, `din` looped from `dout`:
  - `dout` on successive rising `sck` = 1,0,1,0,0,1,0,1.
  - `sck` high/low = 2 clk each.
  - `done` one cycle at t0+33; `rdata`=A5.
- LSB first, `cdiv`=11, `tdat`=8'h01, `din` tied 1:
  - First `dout` bit = 1, then seven 0s.
  - `sck` half period = 16 clk; `done` at t0+257; `rdata`=FF.
- Streaming: `start` held 1 and `tdat` updated on each `done` with 8'h10, 8'h20, 8'h30:
  - Three bytes transmitted in order.
  - `done` pulses 34 clk apart.
  - `ss` high exactly one cycle between bytes.
- Abort: `rstb` pulsed low after the 3rd rising `sck` -> outputs return to reset values immediately, no `done`. The next `start` sends the full new byte.
- Gated clock: stop `clk` for 100 ns mid-byte -> outputs frozen; after resume the transfer completes with correct bits.
